// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C write engine (address + two data bytes)
// between NUM_REQ requesters, with NACK retry, back-off gap and an engine watchdog.

module i2c_txn_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_RETRY = 3,
   parameter int RETRY_GAP = 8,
   parameter int TIMEOUT   = 4096
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [7*NUM_REQ-1:0]    req_addr,
   input  logic [16*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic [NUM_REQ-1:0]      req_err,
   output logic [2:0]              grant_id,
   output logic                    busy,
   output logic                    mst_start,
   output logic [6:0]              mst_addr,
   output logic [7:0]              mst_data1,
   output logic [7:0]              mst_data2,
   input  logic                    mst_done,
   input  logic                    mst_nack
);

   // Handshake: a requester raises req_valid[i] and holds it until it sees a
   // one-cycle req_ack[i] or req_err[i]; it drops req_valid[i] the cycle after.
   // Addr/data are captured only at arbitration, so later changes are ignored.

   localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
   localparam logic [15:0] GAP_LAST  = 16'(RETRY_GAP - 1);
   localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);
   localparam logic [2:0]  LAST_INIT = 3'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LAUNCH   = 3'd1,
      S_WAIT_MST = 3'd2,
      S_BACKOFF  = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   state_t      state, state_n;
   logic [2:0]  last_grant;
   logic [2:0]  grant_q;
   logic [6:0]  addr_q;
   logic [15:0] data_q;
   logic [7:0]  retry_cnt;
   logic [15:0] gap_cnt;
   logic [15:0] wd_cnt;
   logic        ok_q;
   logic        nack_retry;

   logic        any_req;
   logic [2:0]  win_idx;
   logic [6:0]  win_addr;
   logic [15:0] win_data;
   int          rank;
   int          best_rank;

   // Rank 0 is the requester just after last_grant; lowest valid rank wins.
   always_comb begin
      any_req   = 1'b0;
      win_idx   = '0;
      win_addr  = '0;
      win_data  = '0;
      best_rank = NUM_REQ;
      rank      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rank = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
         if (req_valid[i] && (rank < best_rank)) begin
            best_rank = rank;
            any_req   = 1'b1;
            win_idx   = 3'(i);
            win_addr  = req_addr[7*i +: 7];
            win_data  = req_data[16*i +: 16];
         end
      end
   end

   always_comb begin
      state_n    = state;
      nack_retry = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_req) state_n = S_LAUNCH;
         end
         S_LAUNCH: begin
            state_n = S_WAIT_MST;
         end
         S_WAIT_MST: begin
            // done outranks a same-cycle nack; the watchdog only fires when the engine is silent
            if (mst_done) begin
               state_n = S_RESP;
            end else if (mst_nack) begin
               if (retry_cnt < RETRY_MAX) begin
                  nack_retry = 1'b1;
                  state_n    = (RETRY_GAP == 0) ? S_LAUNCH : S_BACKOFF;
               end else begin
                  state_n = S_RESP;
               end
            end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
               state_n = S_RESP;
            end
         end
         S_BACKOFF: begin
            if (gap_cnt == GAP_LAST) state_n = S_LAUNCH;
         end
         S_RESP: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         last_grant <= LAST_INIT;
         grant_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         retry_cnt  <= '0;
         gap_cnt    <= '0;
         wd_cnt     <= '0;
         ok_q       <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  grant_q   <= win_idx;
                  addr_q    <= win_addr;
                  data_q    <= win_data;
                  retry_cnt <= '0;
                  ok_q      <= 1'b0;
               end
            end
            S_LAUNCH: begin
               wd_cnt <= '0;
            end
            S_WAIT_MST: begin
               wd_cnt <= wd_cnt + 16'd1;
               if (mst_done) ok_q <= 1'b1;
               if (nack_retry) begin
                  retry_cnt <= retry_cnt + 8'd1;
                  gap_cnt   <= '0;
               end
            end
            S_BACKOFF: begin
               gap_cnt <= gap_cnt + 16'd1;
            end
            S_RESP: begin
               last_grant <= grant_q;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      req_ack = '0;
      req_err = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ack[i] = (state == S_RESP) && ok_q  && (grant_q == 3'(i));
         req_err[i] = (state == S_RESP) && !ok_q && (grant_q == 3'(i));
      end
   end

   assign busy      = (state != S_IDLE);
   assign mst_start = (state == S_LAUNCH);
   assign grant_id  = grant_q;
   assign mst_addr  = addr_q;
   assign mst_data1 = data_q[15:8];
   assign mst_data2 = data_q[7:0];

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed scenarios plus random rounds, checked against
// a transaction-level model that predicts every start strobe and ack/err pulse by cycle.

module tb_i2c_txn_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int MAX_RETRY = 3;
   localparam int RETRY_GAP = 8;
   localparam int TIMEOUT   = 100;
   localparam int W         = 48;

   localparam logic [1:0] K_DONE   = 2'd0;
   localparam logic [1:0] K_NACK   = 2'd1;
   localparam logic [1:0] K_BOTH   = 2'd2;
   localparam logic [1:0] K_SILENT = 2'd3;

   localparam logic [1:0] E_START = 2'd1;
   localparam logic [1:0] E_ACK   = 2'd2;
   localparam logic [1:0] E_ERR   = 2'd3;

   logic                  clk       = 1'b0;
   logic                  reset     = 1'b1;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [7*NUM_REQ-1:0]  req_addr  = '0;
   logic [16*NUM_REQ-1:0] req_data  = '0;
   logic                  mst_done  = 1'b0;
   logic                  mst_nack  = 1'b0;
   logic [NUM_REQ-1:0]    req_ack;
   logic [NUM_REQ-1:0]    req_err;
   logic [2:0]            grant_id;
   logic                  busy;
   logic                  mst_start;
   logic [6:0]            mst_addr;
   logic [7:0]            mst_data1;
   logic [7:0]            mst_data2;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   logic [9:0]   force_q[$];
   logic [9:0]   eng_q[$];

   logic [6:0]   tb_addr[NUM_REQ];
   logic [15:0]  tb_data[NUM_REQ];
   int           model_last = NUM_REQ - 1;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL global_timeout: sim time exceeded at cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

   i2c_txn_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .MAX_RETRY(MAX_RETRY),
      .RETRY_GAP(RETRY_GAP),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_addr (req_addr),
      .req_data (req_data),
      .req_ack  (req_ack),
      .req_err  (req_err),
      .grant_id (grant_id),
      .busy     (busy),
      .mst_start(mst_start),
      .mst_addr (mst_addr),
      .mst_data1(mst_data1),
      .mst_data2(mst_data2),
      .mst_done (mst_done),
      .mst_nack (mst_nack)
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] ev(input logic [1:0] t, input int id, input logic [6:0] a,
                                       input logic [15:0] d, input int c);
      return {t, 3'(id), a, d, 20'(c)};
   endfunction

   function automatic int rr_pick(input logic [NUM_REQ-1:0] set, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (set[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return 0;
   endfunction

   function automatic logic [9:0] rand_plan();
      int r;
      logic [1:0] k;
      r = $urandom_range(0, 15);
      if (r == 0)     k = K_SILENT;
      else if (r < 3) k = K_BOTH;
      else if (r < 8) k = K_NACK;
      else            k = K_DONE;
      return {k, 8'($urandom_range(1, 30))};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset) begin
         if (mst_start)
            obs_q.push_back(ev(E_START, int'(grant_id), mst_addr, {mst_data1, mst_data2}, cyc));
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i]) begin
               obs_q.push_back(ev(E_ACK, i, 7'd0, 16'd0, cyc));
               req_valid[i] = 1'b0;
            end
            if (req_err[i]) begin
               obs_q.push_back(ev(E_ERR, i, 7'd0, 16'd0, cyc));
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // ---------------- engine responder ----------------
   logic       sched_on = 1'b0;
   int         sched_c  = 0;
   logic [1:0] sched_k  = K_DONE;
   logic [9:0] eng_p;

   always @(negedge clk) begin
      mst_done = 1'b0;
      mst_nack = 1'b0;
      if (reset) begin
         sched_on = 1'b0;
      end else begin
         if (sched_on && (cyc == sched_c)) begin
            sched_on = 1'b0;
            mst_done = (sched_k != K_NACK);
            mst_nack = (sched_k == K_NACK) || (sched_k == K_BOTH);
         end
         if (mst_start) begin
            chk("eng_plan_avail", 64'(eng_q.size() != 0), 64'd1);
            if (eng_q.size() != 0) begin
               eng_p    = eng_q.pop_front();
               sched_on = 1'b1;
               if (eng_p[9:8] == K_SILENT) begin
                  // silent engine: a late done arrives after the watchdog gave up
                  sched_k = K_DONE;
                  sched_c = cyc + TIMEOUT + 2;
               end else begin
                  sched_k = eng_p[9:8];
                  sched_c = cyc + int'(eng_p[7:0]);
               end
            end
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic model_round(input logic [NUM_REQ-1:0] set, input int n0, output int end_c);
      logic [NUM_REQ-1:0] pend;
      logic [9:0] p;
      int c, s, w, d, tries;
      bit fin;
      pend  = set;
      c     = n0;
      end_c = n0;
      while (pend != 0) begin
         w     = rr_pick(pend, model_last);
         s     = c + 1;
         tries = 0;
         fin   = 1'b0;
         while (!fin) begin
            if (force_q.size() != 0) p = force_q.pop_front();
            else                     p = rand_plan();
            eng_q.push_back(p);
            exp_q.push_back(ev(E_START, w, tb_addr[w], tb_data[w], s));
            d = int'(p[7:0]);
            if (p[9:8] == K_DONE || p[9:8] == K_BOTH) begin
               end_c = s + d + 1;
               exp_q.push_back(ev(E_ACK, w, 7'd0, 16'd0, end_c));
               fin = 1'b1;
            end else if (p[9:8] == K_NACK && tries < MAX_RETRY) begin
               tries++;
               s = s + d + 1 + RETRY_GAP;
            end else if (p[9:8] == K_NACK) begin
               end_c = s + d + 1;
               exp_q.push_back(ev(E_ERR, w, 7'd0, 16'd0, end_c));
               fin = 1'b1;
            end else begin
               end_c = s + TIMEOUT + 1;
               exp_q.push_back(ev(E_ERR, w, 7'd0, 16'd0, end_c));
               fin = 1'b1;
            end
         end
         pend[w]    = 1'b0;
         model_last = w;
         c          = end_c + 1;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic [6:0] a, input logic [15:0] d);
      tb_addr[i] = a;
      tb_data[i] = d;
      req_addr[7*i +: 7]   = a;
      req_data[16*i +: 16] = d;
   endtask

   task automatic compare_events(input string tag);
      int n;
      chk({tag, "_n_events"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_event"}, 64'(obs_q[i]), 64'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic run_round(input logic [NUM_REQ-1:0] set, input string tag, input bit mutate);
      int end_c, guard, w;
      @(negedge clk);
      w         = rr_pick(set, model_last);
      req_valid = set;
      model_round(set, cyc, end_c);
      if (mutate) begin
         guard = 0;
         while (obs_q.size() == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         // scribble over the served requester's bus and withdraw it mid-transaction
         req_addr[7*w +: 7]   = ~tb_addr[w];
         req_data[16*w +: 16] = ~tb_data[w];
         req_valid[w]         = 1'b0;
      end
      guard = 0;
      while (cyc < end_c + 4 && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_in_time"}, 64'(guard < 20000), 64'd1);
      compare_events(tag);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      for (int i = 0; i < NUM_REQ; i++) set_req(i, tb_addr[i], tb_data[i]);
   endtask

   task automatic randomize_reqs();
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, 7'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 7'd0, 16'd0);
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_start", 64'(mst_start), 64'd0);
      chk("rst_ack", 64'(req_ack), 64'd0);
      chk("rst_err", 64'(req_err), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_addr", 64'(mst_addr), 64'd0);
      chk("rst_data", 64'({mst_data1, mst_data2}), 64'd0);
      reset = 1'b0;

      // fresh round robin: 0 then 2, then 3,0,1,2
      randomize_reqs();
      run_round(4'b0101, "rr_first", 1'b0);
      run_round(4'b1111, "rr_all", 1'b0);

      // single transaction, done 20 cycles after start
      set_req(1, 7'h50, 16'hA55A);
      force_q.push_back({K_DONE, 8'd20});
      run_round(4'b0010, "basic", 1'b0);

      // two NACKs then done, with the bus changing under the held transaction
      force_q.push_back({K_NACK, 8'd5});
      force_q.push_back({K_NACK, 8'd12});
      force_q.push_back({K_DONE, 8'd7});
      run_round(4'b0100, "retry_ok", 1'b1);

      // retries exhausted
      for (int i = 0; i <= MAX_RETRY; i++) force_q.push_back({K_NACK, 8'(3 + i)});
      run_round(4'b1000, "retry_fail", 1'b0);

      // watchdog expiry followed by a late done
      force_q.push_back({K_SILENT, 8'd0});
      run_round(4'b0001, "timeout", 1'b0);

      // done and nack together
      force_q.push_back({K_BOTH, 8'd10});
      run_round(4'b0010, "done_nack", 1'b0);

      // reset while waiting on the engine
      eng_q.push_back({K_SILENT, 8'd0});
      @(negedge clk);
      req_valid = 4'b0010;
      guard = 0;
      while (obs_q.size() == 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      chk("rstmid_started", 64'(obs_q.size()), 64'd1);
      repeat (3) @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      @(negedge clk);
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_ack", 64'(req_ack), 64'd0);
      chk("rstmid_err", 64'(req_err), 64'd0);
      chk("rstmid_start", 64'(mst_start), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      obs_q.delete();
      eng_q.delete();
      model_last = NUM_REQ - 1;
      repeat (5) @(negedge clk);
      chk("rstmid_quiet", 64'(obs_q.size()), 64'd0);
      run_round(4'b1001, "rstmid_rr", 1'b0);

      // random rounds
      for (int r = 0; r < 20; r++) begin
         randomize_reqs();
         run_round(4'($urandom_range(1, 15)), "rand", 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
